// File: rtl/val2_iter_shifter.sv
// val2_iter_shifter: multi-cycle ARM shifter-operand (Val2) generator.
//
// Purpose: builds Val2 and the shifter carry-out. It shifts STEP bit positions per
// cycle and uses a valid/ready handshake on both the request and the result side.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   flush        synchronous abort; returns to IDLE and drops any result
//   in_valid     request valid; accepted only when in_ready (IDLE)
//   in_ready     high only in IDLE
//   mode         00 reg/imm-shift, 01 reg/reg-shift, 10 imm rotate, 11 mem offset
//   reg_value    Rm operand
//   rs_value     Rs[7:0] shift amount (mode 01)
//   sh_operand   12-bit instruction shifter field
//   c_in         current C flag
//   out_valid    result valid (DONE state)
//   out_ready    consumer accepts result
//   result       Val2, registered
//   carry_out    shifter carry, registered
//   busy         state != IDLE
module val2_iter_shifter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] reg_value,
    input  logic [7:0]        rs_value,
    input  logic [11:0]       sh_operand,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              busy
);

    localparam int unsigned     CntW   = $clog2(DATA_W + 2);
    localparam logic [CntW-1:0] StepC  = CntW'(STEP);
    localparam logic [CntW-1:0] DataWC = CntW'(DATA_W);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [2:0] {OpLsl, OpLsr, OpAsr, OpRor, OpRrx} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [CntW-1:0]   rem_q, rem_d;
    logic              carry_q, carry_d;

    // Request decode: what the accept edge loads.
    op_e               ld_op;
    logic [DATA_W-1:0] ld_value;
    logic [CntW-1:0]   ld_n;
    logic              ld_carry;
    int unsigned       amt_int, a_int, n_int;

    always_comb begin
        ld_op    = OpLsl;
        ld_value = reg_value;
        ld_carry = c_in;
        amt_int  = 32'(sh_operand[11:7]);
        a_int    = 32'(rs_value);
        n_int    = 0;
        unique case (mode)
            2'b00: begin
                case (sh_operand[6:5])
                    2'b00: begin
                        ld_op = OpLsl;
                        n_int = amt_int;
                    end
                    2'b01: begin
                        ld_op = OpLsr;
                        n_int = (amt_int == 0) ? DATA_W : amt_int;
                    end
                    2'b10: begin
                        ld_op = OpAsr;
                        n_int = (amt_int == 0) ? DATA_W : amt_int;
                    end
                    default: begin
                        // ROR #0 encodes RRX: a single rotate through carry.
                        if (amt_int == 0) begin
                            ld_op = OpRrx;
                            n_int = 1;
                        end else begin
                            ld_op = OpRor;
                            n_int = amt_int;
                        end
                    end
                endcase
            end
            2'b01: begin
                // Saturate so the counter only sees amounts that still change the result.
                case (sh_operand[6:5])
                    2'b00: begin
                        ld_op = OpLsl;
                        n_int = (a_int > DATA_W + 1) ? DATA_W + 1 : a_int;
                    end
                    2'b01: begin
                        ld_op = OpLsr;
                        n_int = (a_int > DATA_W + 1) ? DATA_W + 1 : a_int;
                    end
                    2'b10: begin
                        ld_op = OpAsr;
                        n_int = (a_int > DATA_W) ? DATA_W : a_int;
                    end
                    default: begin
                        ld_op = OpRor;
                        n_int = a_int % DATA_W;
                        // Full-turn rotate: value unchanged, carry is the MSB.
                        if (a_int != 0 && n_int == 0) begin
                            ld_carry = reg_value[DATA_W-1];
                        end
                    end
                endcase
            end
            2'b10: begin
                ld_op    = OpRor;
                ld_value = DATA_W'(sh_operand[7:0]);
                n_int    = 2 * 32'(sh_operand[11:8]);
            end
            default: begin
                ld_value = {{(DATA_W - 12){sh_operand[11]}}, sh_operand};
                n_int    = 0;
            end
        endcase
        ld_n = CntW'(n_int);
    end

    // One SHIFT step of k = min(STEP, remaining) positions.
    logic [CntW-1:0]          step_k, sh_m1;
    logic [DATA_W-1:0]        step_value;
    logic                     step_carry;
    logic signed [DATA_W-1:0] sval, asr_val;
    logic [DATA_W-1:0]        msb_mask, lsb_mask;

    always_comb begin
        step_k   = (rem_q > StepC) ? StepC : rem_q;
        sh_m1    = step_k - 1'b1;
        sval     = value_q;
        asr_val  = sval >>> step_k;
        // Select the last bit shifted out: bit DATA_W-k (left) or bit k-1 (right).
        msb_mask = {1'b1, {(DATA_W - 1){1'b0}}} >> sh_m1;
        lsb_mask = {{(DATA_W - 1){1'b0}}, 1'b1} << sh_m1;
        step_value = value_q;
        step_carry = carry_q;
        unique case (op_q)
            OpLsl: begin
                step_value = value_q << step_k;
                step_carry = |(value_q & msb_mask);
            end
            OpLsr: begin
                step_value = value_q >> step_k;
                step_carry = |(value_q & lsb_mask);
            end
            OpAsr: begin
                step_value = asr_val;
                step_carry = |(value_q & lsb_mask);
            end
            OpRor: begin
                step_value = (value_q >> step_k) | (value_q << (DataWC - step_k));
                step_carry = step_value[DATA_W-1];
            end
            OpRrx: begin
                step_value = {carry_q, value_q[DATA_W-1:1]};
                step_carry = value_q[0];
            end
            default: begin
                step_value = value_q;
                step_carry = carry_q;
            end
        endcase
    end

    // Next-state logic; flush outranks both accept and out_ready.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        value_d = value_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d    = ld_op;
                        value_d = ld_value;
                        rem_d   = ld_n;
                        carry_d = ld_carry;
                        state_d = (ld_n == '0) ? StDone : StShift;
                    end
                end
                StShift: begin
                    value_d = step_value;
                    carry_d = step_carry;
                    rem_d   = rem_q - step_k;
                    if (rem_q == step_k) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpLsl;
            value_q <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            value_q <= value_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        result    = value_q;
        carry_out = carry_q;
    end

endmodule
